riscv_dmem: RTL and testbench

- Data-memory responder for the RV32I core: the far end of the load/store control signals the core's controller produces.
- Accepts one load or store request per valid/ready handshake and applies byte-lane alignment for the access width.
- Returns load data sign- or zero-extended per funct3, after a configurable number of wait states.
- Backed by an internal word-wide register array; sits between the core's memory stage and the writeback mux.

---
 rtl/riscv_dmem_if.sv | 43 ++++
 rtl/riscv_dmem.sv | 229 ++++++++++++++++++++++
 tb/tb_riscv_dmem.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_if.sv
// riscv_dmem_if: request/response bus between the core memory stage and the
// data-memory responder. The master side is the core, the slave side is riscv_dmem.
interface riscv_dmem_if;
    logic        dmem_req;
    logic        dmem_ready;
    logic        dmem_wr_en;
    logic [3:0]  dmem_byte_sel;
    logic [2:0]  dmem_funct3;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic        dmem_busy;

    modport master (
        output dmem_req,
        output dmem_wr_en,
        output dmem_byte_sel,
        output dmem_funct3,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rvalid,
        input  dmem_rdata,
        input  dmem_err,
        input  dmem_busy
    );

    modport slave (
        input  dmem_req,
        input  dmem_wr_en,
        input  dmem_byte_sel,
        input  dmem_funct3,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rvalid,
        output dmem_rdata,
        output dmem_err,
        output dmem_busy
    );
endinterface

// File: rtl/riscv_dmem.sv
// riscv_dmem: RV32I data-memory responder.
// One load/store per valid/ready handshake, byte-lane aligned, with WAIT_CYCLES
// wait states between acceptance and the one-cycle response strobe.
// Optional macro RISCV_DMEM_MISALIGN_CHK_EN: when defined, misaligned half/word
// accesses are flagged with err and never write the array; when undefined, the
// low address bits are forced to natural alignment and err stays 0.
module riscv_dmem #(
    parameter int AWIDTH      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    riscv_dmem_if.slave  dmem
);

    localparam int         DEPTH     = 1 << AWIDTH;
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_WAIT   = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;
    localparam logic       HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // Sign/zero extension of the right-shifted load word by funct3.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  funct3);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext_s;
        byte_s = signed'(word[7:0]);
        half_s = signed'(word[15:0]);
        ext_s  = signed'(word);
        case (funct3)
            3'b000:  ext_s = byte_s;
            3'b001:  ext_s = half_s;
            3'b100:  ext_s = signed'({24'd0, word[7:0]});
            3'b101:  ext_s = signed'({16'd0, word[15:0]});
            default: ext_s = signed'(word);
        endcase
        return unsigned'(ext_s);
    endfunction

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=00.
    function automatic logic is_misaligned(input logic [3:0] byte_sel,
                                           input logic [1:0] off);
        logic is_half;
        logic is_word;
        is_half = byte_sel[1] && !byte_sel[3];
        is_word = byte_sel[3];
        return (is_half && off[0]) || (is_word && (off != 2'b00));
    endfunction

    // Natural alignment: word -> 00, half -> {a1,0}, byte -> unchanged.
    function automatic logic [1:0] force_align(input logic [3:0] byte_sel,
                                               input logic [1:0] off);
        if (byte_sel[3]) begin
            return 2'b00;
        end else if (byte_sel[1]) begin
            return {off[1], 1'b0};
        end
        return off;
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        wr_en_q, wr_en_d;
    logic [3:0]  byte_sel_q, byte_sel_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        ready;
    logic        accept;
    logic        from_wait;
    logic        enter_resp;

    logic        acc_wr_en;
    logic [3:0]  acc_byte_sel;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [1:0]        off;
    logic              misaligned;
    logic [AWIDTH-1:0] word_idx;
    logic [7:0]        lane_wide;
    logic [3:0]        lane_mask;
    logic [31:0]       wdata_sh;
    logic [31:0]       rd_word;
    logic              mem_we;
    logic              unused_addr_hi;

    assign ready     = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept    = dmem.dmem_req && ready;
    assign from_wait = (state_q == ST_WAIT);

    assign dmem.dmem_ready  = ready;
    assign dmem.dmem_rvalid = (state_q == ST_RESP);
    assign dmem.dmem_busy   = (state_q == ST_WAIT);
    assign dmem.dmem_rdata  = rdata_q;
    assign dmem.dmem_err    = err_q;

    // Access source: live request when entering RESP straight from an accept,
    // latched request when leaving WAIT.
    always_comb begin
        acc_wr_en    = dmem.dmem_wr_en;
        acc_byte_sel = dmem.dmem_byte_sel;
        acc_funct3   = dmem.dmem_funct3;
        acc_addr     = dmem.dmem_addr;
        acc_wdata    = dmem.dmem_wdata;
        if (from_wait) begin
            acc_wr_en    = wr_en_q;
            acc_byte_sel = byte_sel_q;
            acc_funct3   = funct3_q;
            acc_addr     = addr_q;
            acc_wdata    = wdata_q;
        end
    end

    // The array is touched only on the edge that enters RESP.
    assign enter_resp = from_wait ? (cnt_q == 4'd0) : (accept && !HAS_WAIT);

    // Lane offset and alignment policy for the access being committed.
    always_comb begin
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
        off        = acc_addr[1:0];
        misaligned = is_misaligned(acc_byte_sel, acc_addr[1:0]);
`else
        off        = force_align(acc_byte_sel, acc_addr[1:0]);
        misaligned = 1'b0;
`endif
    end

    assign word_idx       = acc_addr[AWIDTH+1:2];
    assign unused_addr_hi = ^{acc_addr[31:AWIDTH+2], acc_addr[1:0]};
    assign lane_wide      = {4'b0000, acc_byte_sel} << off;
    assign lane_mask      = misaligned ? 4'b0000 : lane_wide[3:0];
    assign wdata_sh       = acc_wdata << {off, 3'b000};
    assign rd_word        = mem[word_idx] >> {off, 3'b000};
    assign mem_we         = enter_resp && acc_wr_en && !i_rst;

    // Next-state, wait counter and response data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            err_d   = misaligned;
            rdata_d = (acc_wr_en || misaligned) ? 32'd0 : extend_load(rd_word, acc_funct3);
        end
    end

    // Request capture on accept.
    always_comb begin
        wr_en_d    = wr_en_q;
        byte_sel_d = byte_sel_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (accept) begin
            wr_en_d    = dmem.dmem_wr_en;
            byte_sel_d = dmem.dmem_byte_sel;
            funct3_d   = dmem.dmem_funct3;
            addr_d     = dmem.dmem_addr;
            wdata_d    = dmem.dmem_wdata;
        end
    end

    // Control state and response registers, asynchronously reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latched request fields carry no reset; they are only read in WAIT.
    always_ff @(posedge i_clk) begin
        wr_en_q    <= wr_en_d;
        byte_sel_q <= byte_sel_d;
        funct3_q   <= funct3_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
    end

    // Byte-lane write of the array; contents persist across reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && lane_mask[b]) begin
                mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem.sv
// tb_riscv_dmem: scoreboard bench for riscv_dmem with a zero-wait and a
// three-wait-state instance sharing one request field bus.
module tb_riscv_dmem;

    localparam logic [3:0] BS_B = 4'b0001;
    localparam logic [3:0] BS_H = 4'b0011;
    localparam logic [3:0] BS_W = 4'b1111;
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req3, wr_en;
    logic [3:0]  bsel;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_dmem_if if0 ();
    riscv_dmem_if if3 ();

    assign if0.dmem_req      = req0;
    assign if0.dmem_wr_en    = wr_en;
    assign if0.dmem_byte_sel = bsel;
    assign if0.dmem_funct3   = f3;
    assign if0.dmem_addr     = addr;
    assign if0.dmem_wdata    = wdata;
    assign if3.dmem_req      = req3;
    assign if3.dmem_wr_en    = wr_en;
    assign if3.dmem_byte_sel = bsel;
    assign if3.dmem_funct3   = f3;
    assign if3.dmem_addr     = addr;
    assign if3.dmem_wdata    = wdata;

    riscv_dmem #(.AWIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .dmem  (if0)
    );

    riscv_dmem #(.AWIDTH(10), .WAIT_CYCLES(3)) u_dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .dmem  (if3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: pop the oldest expectation whenever a response strobe appears.
    always @(negedge clk) begin
        if (if0.dmem_rvalid === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut0 unexpected rvalid at cycle %0d", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("dut0 rdata", if0.dmem_rdata, e0.rdata);
                chk("dut0 err", {31'd0, if0.dmem_err}, {31'd0, e0.err});
                chk("dut0 latency", cyc, e0.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (if3.dmem_rvalid === 1'b1) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut3 unexpected rvalid at cycle %0d", cyc);
            end else begin
                e3 = q3.pop_front();
                chk("dut3 rdata", if3.dmem_rdata, e3.rdata);
                chk("dut3 err", {31'd0, if3.dmem_err}, {31'd0, e3.err});
                chk("dut3 latency", cyc, e3.cyc);
            end
        end
    end

    // Present one request to the chosen instance and hold it until accepted.
    task automatic issue(input int dut, input logic w, input logic [3:0] b,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        wr_en = w;
        bsel  = b;
        f3    = f;
        addr  = a;
        wdata = d;
        req0  = (dut == 0);
        req3  = (dut != 0);
        n = 0;
        while (((dut == 0) ? if0.dmem_ready : if3.dmem_ready) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL ready timeout: dut%0d addr 0x%08h never accepted", dut, a);
            req0 = 1'b0;
            req3 = 1'b0;
        end else begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = cyc + 1 + ((dut == 0) ? 0 : 3);
            if (push) begin
                if (dut == 0) q0.push_back(e);
                else          q3.push_back(e);
            end
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req0 = 1'b0;
        req3 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (q0.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL drain: pending dut0=%0d dut3=%0d expected 0 0", q0.size(), q3.size());
            q0.delete();
            q3.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req3  = 1'b0;
        wr_en = 1'b0;
        bsel  = 4'd0;
        f3    = 3'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset dut0 ready", {31'd0, if0.dmem_ready}, 32'd1);
        chk("reset dut0 rvalid", {31'd0, if0.dmem_rvalid}, 32'd0);
        chk("reset dut0 rdata", if0.dmem_rdata, 32'd0);
        chk("reset dut0 err", {31'd0, if0.dmem_err}, 32'd0);
        chk("reset dut0 busy", {31'd0, if0.dmem_busy}, 32'd0);
        chk("reset dut3 ready", {31'd0, if3.dmem_ready}, 32'd1);
        chk("reset dut3 busy", {31'd0, if3.dmem_busy}, 32'd0);
        chk("reset dut3 rvalid", {31'd0, if3.dmem_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait instance: word store/load, extensions, lane stores, aliasing.
        issue(0, 1'b1, BS_W, F_W,  32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, BS_W, F_W,  32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(0, 1'b1, BS_W, F_W,  32'h20, 32'h80F17F81, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, BS_B, F_B,  32'h20, 32'h0, 32'hFFFFFF81, 1'b0, 1'b1);
        issue(0, 1'b0, BS_B, F_BU, 32'h20, 32'h0, 32'h00000081, 1'b0, 1'b1);
        issue(0, 1'b0, BS_H, F_H,  32'h22, 32'h0, 32'hFFFF80F1, 1'b0, 1'b1);
        issue(0, 1'b0, BS_H, F_HU, 32'h22, 32'h0, 32'h000080F1, 1'b0, 1'b1);
        issue(0, 1'b0, BS_B, F_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        issue(0, 1'b0, BS_B, F_BU, 32'h21, 32'h0, 32'h0000007F, 1'b0, 1'b1);
        issue(0, 1'b1, BS_W, F_W,  32'h30, 32'h11223344, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b1, BS_B, F_B,  32'h31, 32'h000000AA, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, BS_W, F_W,  32'h30, 32'h0, 32'h1122AA44, 1'b0, 1'b1);
        issue(0, 1'b1, BS_H, F_H,  32'h32, 32'h0000BEEF, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, BS_W, F_W,  32'h30, 32'h0, 32'hBEEFAA44, 1'b0, 1'b1);
        issue(0, 1'b0, BS_H, F_H,  32'h30, 32'h0, 32'hFFFFAA44, 1'b0, 1'b1);
        issue(0, 1'b0, BS_W, F_W,  32'h1010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        issue(0, 1'b1, BS_W, F_W,  32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
`ifdef RISCV_DMEM_MISALIGN_CHK_EN
        issue(0, 1'b1, BS_W, F_W,  32'h42, 32'h11111111, 32'h0, 1'b1, 1'b1);
        issue(0, 1'b0, BS_W, F_W,  32'h40, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        issue(0, 1'b0, BS_H, F_H,  32'h41, 32'h0, 32'h0, 1'b1, 1'b1);
`else
        issue(0, 1'b1, BS_W, F_W,  32'h42, 32'h11111111, 32'h0, 1'b0, 1'b1);
        issue(0, 1'b0, BS_W, F_W,  32'h40, 32'h0, 32'h11111111, 1'b0, 1'b1);
        issue(0, 1'b0, BS_H, F_H,  32'h41, 32'h0, 32'h00001111, 1'b0, 1'b1);
`endif
        idle();
        drain();

        // Three-wait instance: busy/ready window, then a back-to-back accept in RESP.
        issue(3, 1'b1, BS_W, F_W, 32'h60, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) req3 = 1'b0;
            chk("wait busy", {31'd0, if3.dmem_busy}, 32'd1);
            chk("wait ready", {31'd0, if3.dmem_ready}, 32'd0);
        end
        issue(3, 1'b0, BS_W, F_W, 32'h60, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
        idle();
        drain();

        // Reset during WAIT drops an uncommitted store.
        issue(3, 1'b1, BS_W, F_W, 32'h50, 32'h01234567, 32'h0, 1'b0, 1'b1);
        idle();
        drain();
        issue(3, 1'b1, BS_W, F_W, 32'h50, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req3 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        chk("abort ready", {31'd0, if3.dmem_ready}, 32'd1);
        chk("abort busy", {31'd0, if3.dmem_busy}, 32'd0);
        chk("abort rvalid", {31'd0, if3.dmem_rvalid}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(3, 1'b0, BS_W, F_W, 32'h50, 32'h0, 32'h01234567, 1'b0, 1'b1);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
